lcd_nibble_reader: RTL and testbench

LCD_NIBBLE_READER -- requirements
Module: lcd_nibble_reader

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_phase_timer.sv | 27 ++
 rtl/lcd_nibble_reader.sv | 157 +++++++++++++++
 tb/tb_lcd_nibble_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared FSM encoding, default bus timing and counter sizing helpers for the
// LCD nibble reader.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_E1    = 3'd2,
    ST_GAP   = 3'd3,
    ST_E2    = 3'd4,
    ST_HOLD  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam int unsigned T_SETUP_DEFAULT = 2;
  localparam int unsigned T_EHIGH_DEFAULT = 12;
  localparam int unsigned T_GAP_DEFAULT   = 50;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold max_count-1, never fewer than one.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times each phase; zero_c flags the last cycle of
// the phase.
module lcd_phase_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/lcd_nibble_reader.sv
// Reads one byte from an HD44780-style LCD in 4-bit mode: two E strobes, high
// nibble first, with RS/RW held stable around the strobes.
module lcd_nibble_reader
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEFAULT,
  parameter int unsigned T_EHIGH = T_EHIGH_DEFAULT,
  parameter int unsigned T_GAP   = T_GAP_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs_sel,
  input  logic [3:0] lcd_d_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_d_oe,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic       valid,
  output logic       busy
);

  localparam int unsigned T_MAX = max3(T_SETUP, T_EHIGH, T_GAP);
  localparam int unsigned CNT_W = cnt_width(T_MAX);

  state_t             state;
  state_t             state_next;
  logic               zero_c;
  logic               load_c;
  logic [CNT_W-1:0]   load_value_c;
  logic               rs_lat;
  logic               rs_next_c;
  logic               lcd_e_c;
  logic               lcd_rs_c;
  logic               lcd_rw_c;
  logic               lcd_d_oe_c;
  logic               valid_c;
  logic               busy_c;

  // Dwell time minus one for the phase being entered.
  function automatic logic [CNT_W-1:0] phase_load(input state_t s);
    case (s)
      ST_SETUP, ST_HOLD: return CNT_W'(T_SETUP - 1);
      ST_E1, ST_E2:      return CNT_W'(T_EHIGH - 1);
      ST_GAP:            return CNT_W'(T_GAP - 1);
      default:           return '0;
    endcase
  endfunction

  lcd_phase_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load_c),
    .load_value(load_value_c),
    .zero_c    (zero_c)
  );

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rs_lat    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_d_oe  <= 1'b1;
      rd_data   <= 8'h00;
      busy_flag <= 1'b1;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state    <= state_next;
      rs_lat   <= rs_next_c;
      lcd_e    <= lcd_e_c;
      lcd_rs   <= lcd_rs_c;
      lcd_rw   <= lcd_rw_c;
      lcd_d_oe <= lcd_d_oe_c;
      valid    <= valid_c;
      busy     <= busy_c;
      if (state == ST_E1 && zero_c) begin
        rd_data[7:4] <= lcd_d_in;
      end
      if (state == ST_E2 && zero_c) begin
        rd_data[3:0] <= lcd_d_in;
      end
      // Both nibbles are settled by the time HOLD hands over to DONE.
      if (state == ST_HOLD && state_next == ST_DONE && !rs_lat) begin
        busy_flag <= rd_data[7];
      end
    end
  end

  // Next-state and phase counter load.
  always_comb begin
    state_next   = state;
    load_c       = 1'b0;
    load_value_c = '0;
    rs_next_c    = rs_lat;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETUP;
          rs_next_c  = rs_sel;
        end
      end
      ST_SETUP: if (zero_c) state_next = ST_E1;
      ST_E1:    if (zero_c) state_next = ST_GAP;
      ST_GAP:   if (zero_c) state_next = ST_E2;
      ST_E2:    if (zero_c) state_next = ST_HOLD;
      ST_HOLD:  if (zero_c) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (state_next != state) begin
      load_c       = 1'b1;
      load_value_c = phase_load(state_next);
    end
  end

  // Pad and handshake levels for the state about to be entered.
  always_comb begin
    lcd_e_c    = 1'b0;
    lcd_rw_c   = 1'b0;
    lcd_rs_c   = 1'b0;
    lcd_d_oe_c = 1'b1;
    valid_c    = 1'b0;
    busy_c     = 1'b1;
    case (state_next)
      ST_IDLE: begin
        busy_c = 1'b0;
      end
      ST_SETUP, ST_GAP, ST_HOLD: begin
        lcd_rw_c   = 1'b1;
        lcd_rs_c   = rs_next_c;
        lcd_d_oe_c = 1'b0;
      end
      ST_E1, ST_E2: begin
        lcd_e_c    = 1'b1;
        lcd_rw_c   = 1'b1;
        lcd_rs_c   = rs_next_c;
        lcd_d_oe_c = 1'b0;
      end
      ST_DONE: begin
        lcd_d_oe_c = 1'b0;
        valid_c    = 1'b1;
      end
      default: begin
        busy_c = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// Scoreboard bench for lcd_nibble_reader: an LCD model answers the E strobes,
// expectations are queued at issue and checked whenever valid pulses.
module tb_lcd_nibble_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       rs_sel = 1'b0;
  logic [3:0] lcd_d_in;
  logic       lcd_e, lcd_rs, lcd_rw, lcd_d_oe;
  logic [7:0] rd_data;
  logic       busy_flag, valid, busy;

  typedef struct {
    logic [7:0] data;
    logic       bf;
    logic       rs;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         valids = 0;
  logic       bf_model = 1'b1;
  logic [3:0] nib_hi = 4'h0;
  logic [3:0] nib_lo = 4'h0;
  logic       second = 1'b0;
  logic       e_prev = 1'b0;
  logic       prev_rs = 1'b0;
  logic       prev_rw = 1'b0;
  logic       rs_ok = 1'b1;
  int         e_run = 0;
  int         low_run = 0;

  lcd_nibble_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rs_sel   (rs_sel),
    .lcd_d_in (lcd_d_in),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_d_oe (lcd_d_oe),
    .rd_data  (rd_data),
    .busy_flag(busy_flag),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LCD drives the selected nibble only while E is high; junk otherwise.
  assign lcd_d_in = lcd_e ? (second ? nib_lo : nib_hi) : 4'hF;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_lcd_e"}, 32'(lcd_e), 32'd0);
    check({tag, "_lcd_rw"}, 32'(lcd_rw), 32'd0);
    check({tag, "_lcd_rs"}, 32'(lcd_rs), 32'd0);
    check({tag, "_lcd_d_oe"}, 32'(lcd_d_oe), 32'd1);
    check({tag, "_rd_data"}, 32'(rd_data), 32'h00);
    check({tag, "_busy_flag"}, 32'(busy_flag), 32'd1);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; acceptance happens on the next posedge.
  task automatic issue(input logic rs, input logic [3:0] hi, input logic [3:0] lo,
                       input bit track);
    exp_t e;
    nib_hi = hi;
    nib_lo = lo;
    rs_sel = rs;
    start  = 1'b1;
    if (track) begin
      if (!rs) bf_model = hi[3];
      e.data = {hi, lo};
      e.bf   = bf_model;
      e.rs   = rs;
      e.cyc  = cyc + 79;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    rs_sel = ~rs;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < max_cyc), 32'd1);
  endtask

  // Protocol monitor and scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    check("oe_rw_exclusive", 32'(lcd_d_oe & lcd_rw), 32'd0);
    if (lcd_e && e_prev) begin
      check("rs_stable_while_e", 32'(lcd_rs), 32'(prev_rs));
      check("rw_stable_while_e", 32'(lcd_rw), 32'(prev_rw));
    end
    if (lcd_e) begin
      if (!e_prev && second) check("e_gap_width", 32'(low_run), 32'd50);
      e_run++;
      low_run = 0;
    end else begin
      if (e_prev) check("e_high_width", 32'(e_run), 32'd12);
      e_run = 0;
      low_run++;
    end
    if (lcd_rw && sb_q.size() != 0 && lcd_rs !== sb_q[0].rs) rs_ok = 1'b0;
    if (valid) begin
      valids++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid=1 at cycle %0d expected no pulse", cyc);
      end else begin
        e = sb_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(e.data));
        check("busy_flag", 32'(busy_flag), 32'(e.bf));
        check("valid_cycle", 32'(cyc), 32'(e.cyc));
        check("lcd_rs_held", 32'(rs_ok), 32'd1);
        rs_ok = 1'b1;
      end
    end
    if (!busy) second = 1'b0;
    else if (e_prev && !lcd_e) second = 1'b1;
    e_prev  = lcd_e;
    prev_rs = lcd_rs;
    prev_rw = lcd_rw;
  end

  initial begin
    int v0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Status read then data read, rs_sel toggled right after acceptance.
    issue(1'b0, 4'h8, 4'h5, 1'b1);
    wait_drain(300);
    issue(1'b1, 4'h4, 4'h1, 1'b1);
    wait_drain(300);
    issue(1'b0, 4'h3, 4'hC, 1'b1);
    wait_drain(300);
    issue(1'b1, 4'hA, 4'h7, 1'b1);
    wait_drain(300);

    // Starts during E1 and GAP are dropped.
    v0 = valids;
    issue(1'b0, 4'h6, 4'h9, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(300);
    repeat (100) @(negedge clk);
    check("single_valid_on_overlap", 32'(valids - v0), 32'd1);

    // Reset in GAP aborts the read; outputs reset without waiting for a clock.
    v0 = valids;
    issue(1'b1, 4'hB, 4'h2, 1'b0);
    repeat (30) @(negedge clk);
    check("gap_lcd_rs_before_reset", 32'(lcd_rs), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_values("mid_reset");
    bf_model = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (120) @(negedge clk);
    check("no_valid_after_abort", 32'(valids - v0), 32'd0);
    issue(1'b0, 4'h7, 4'hE, 1'b1);
    wait_drain(300);

    // Held start: three reads 80 cycles apart.
    v0 = valids;
    nib_hi = 4'h2;
    nib_lo = 4'h9;
    rs_sel = 1'b0;
    start  = 1'b1;
    bf_model = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.data = 8'h29;
      e.bf   = 1'b0;
      e.rs   = 1'b0;
      e.cyc  = cyc + 79 + 80 * i;
      sb_q.push_back(e);
    end
    begin
      int n;
      n = 0;
      while (valids < v0 + 3 && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("held_start_three_done", 32'(n < 400), 32'd1);
    end
    start = 1'b0;
    wait_drain(300);
    repeat (150) @(negedge clk);
    check("held_start_valid_count", 32'(valids - v0), 32'd3);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
